reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Synthesisable successor to the bench-driven reset pulse: generates NUM_DOMAINS staggered
//  active-low domain resets from the board oscillator clock. Sources: power-on/PLL, debounced
//  push button, software request (8051 SFR / debug port). Sits beside the PLL at top level and
//  feeds the core, peripheral and memory-interface reset trees.
// PARAMETERS
//  NUM_DOMAINS      4   number of domain resets (1..8); released in ascending index order
//  POR_CYCLES      30   clk edges all domains are held in reset after entering ASSERT (>=1)
//  STAGGER_CYCLES  10   clk edges between releases of domain k-1 and domain k (>=1)
//  DEBOUNCE_CYCLES 16   consecutive stable synchronised cycles needed to flip button level (>=1)
//  SYNC_STAGES      2   flops in push_button synchroniser (>=2)
// PORTS
//  clk             in   1            oscillator clock (12 MHz nominal)
//  reset_n         in   1            asynchronous, active-low master reset (PLL lock / POR)
//  push_button     in   1            raw asynchronous button, active-high
//  sw_reset_req    in   1            synchronous single-cycle software reset request
//  domain_reset_n  out  NUM_DOMAINS  registered active-low domain resets
//  reset_busy      out  1            1 while any domain is in reset
//  reset_cause     out  2            00 power-on, 01 button, 10 software; held until next trigger
// BEHAVIOUR
//  - Clock and reset: one clock, clk. reset_n is asynchronous and active-low. reset_n low ->
//    immediately: domain_reset_n = all 0, reset_busy = 1, reset_cause = 00, state ASSERT,
//    counter = 0, synchroniser and debounced level = 0, debounce counter = 0.
//  - States: ASSERT -> RELEASE -> RUN. All outputs come from flops; no combinational path
//    from any input to any output.
//  - ASSERT: all domain resets low. Counter advances one per edge only while the debounced
//    button level is 0. On reaching POR_CYCLES: release domain 0 on that edge, move to RELEASE.
//  - RELEASE: every STAGGER_CYCLES edges, release the next domain.
//    Domain k is released at edge POR_CYCLES + k*STAGGER_CYCLES, counted from ASSERT entry.
//    The edge that releases domain NUM_DOMAINS-1 also clears reset_busy and enters RUN.
//    NUM_DOMAINS = 1 goes straight from ASSERT to RUN.
//  - Button path: SYNC_STAGES synchroniser, then debouncer. The debounced level flips when the
//    synchronised value has differed from it for DEBOUNCE_CYCLES consecutive edges. Any
//    agreeing sample clears the debounce count.
//  - Trigger = rising edge of debounced level (registered), or sw_reset_req = 1.
//  - Trigger in any state, on the edge it is sampled:
//    - state <= ASSERT, counter <= 0;
//    - all domain_reset_n <= 0 and reset_busy <= 1;
//    - reset_cause updated.
//    A trigger during ASSERT/RELEASE restarts the sequence: re-asserts released domains and
//    restarts the count.
//  - Simultaneous button and software triggers: cause = 01 (button wins).
//  - Held button: ASSERT stays frozen while debounced level = 1. Releasing it counts as no
//    trigger; the count resumes once the debounced level returns to 0.
//  - Counter width: $clog2(POR_CYCLES + NUM_DOMAINS*STAGGER_CYCLES + 1). No wrap is reachable.
//  - Glitch shorter than DEBOUNCE_CYCLES on push_button: no trigger, no output change.
// TESTING
//  1. reset_n low 6 cycles, then high, defaults -> domain_reset_n goes 0x0 -> 0x1 @ edge 30,
//     0x3 @ 40, 0x7 @ 50, 0xF @ 60; reset_busy falls @ 60; cause = 00.
//  2. RUN, sw_reset_req pulse at edge E -> all 0 after E; cause = 10; domains re-release at
//     E+30/40/50/60.
//  3. RUN, push_button high held 100 cycles -> domains low at edge 19 after press
//     (2 sync + 16 debounce + 1); stay low while held; after release, domain 0 frees 30 edges
//     after the debounced level falls.
//  4. push_button 10-cycle glitch -> no change on any output.
//  5. sw_reset_req at edge 45 of a sequence (domains 0,1 free) -> all re-asserted;
//     new releases at +30/40/50/60.
//  6. Button debounced rise and sw_reset_req on the same edge -> cause = 01.
//     reset_n pulsed low mid-RELEASE -> outputs 0 asynchronously, cause = 00.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered active-low domain resets from power-on, debounced button or software request
module reset_sequencer #(
  parameter int NUM_DOMAINS     = 4,
  parameter int POR_CYCLES      = 30,
  parameter int STAGGER_CYCLES  = 10,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_button,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   reset_busy,
  output logic [1:0]             reset_cause
);
  localparam int LAST = POR_CYCLES + (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int W    = $clog2(POR_CYCLES + NUM_DOMAINS * STAGGER_CYCLES + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_RUN} state_t;
  state_t                 state, state_d;
  logic [W-1:0]           cnt, cnt_d, cnt_inc;
  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0]          db_cnt;
  logic                   deb, deb_q, btn_trig, trig;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic                   busy_d;
  logic [1:0]             cause_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync   <= '0;
      deb    <= 1'b0;
      deb_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], push_button};
      deb_q <= deb;
      if (sync[SYNC_STAGES-1] == deb) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb    <= ~deb;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + DW'(1);
    end
  assign btn_trig = deb & ~deb_q;
  assign trig     = btn_trig | sw_reset_req;
  assign cnt_inc  = cnt + W'(1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state          <= S_ASSERT;
      cnt            <= '0;
      domain_reset_n <= '0;
      reset_busy     <= 1'b1;
      reset_cause    <= 2'b00;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      domain_reset_n <= dom_d;
      reset_busy     <= busy_d;
      reset_cause    <= cause_d;
    end
  // ASSERT only counts while the button is not held; RELEASE always counts
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (trig) begin
      state_d = S_ASSERT;
      cnt_d   = '0;
    end else if (state == S_RELEASE || (state == S_ASSERT && !deb)) begin
      cnt_d = cnt_inc;
      if (cnt_inc == W'(LAST)) state_d = S_RUN;
      else if (cnt_inc == W'(POR_CYCLES)) state_d = S_RELEASE;
    end
  end
  // domain k is free once the count reaches its release edge; the count holds in RUN
  always_comb begin
    for (int k = 0; k < NUM_DOMAINS; k++)
      dom_d[k] = cnt_d >= W'(POR_CYCLES + k * STAGGER_CYCLES);
    busy_d  = ~&dom_d;
    cause_d = btn_trig ? 2'b01 : sw_reset_req ? 2'b10 : reset_cause;
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios plus random button/software stimulus against a behavioural model
module tb_reset_sequencer;
  localparam int N = 4, POR = 30, STG = 10, DB = 16, SS = 2;
  localparam int LAST = POR + (N - 1) * STG;
  logic         clk = 1'b0, reset_n = 1'b0, push_button = 1'b0, sw_reset_req = 1'b0;
  logic [N-1:0] domain_reset_n;
  logic         reset_busy;
  logic [1:0]   reset_cause;
  int           vectors = 0, miscompares = 0;
  int           act;
  bit           m_deb, rose_pend;
  bit           pbq[$];
  bit           sh[$];
  logic [1:0]   m_cause;
  reset_sequencer #(.NUM_DOMAINS(N), .POR_CYCLES(POR), .STAGGER_CYCLES(STG),
                    .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .push_button(push_button), .sw_reset_req(sw_reset_req),
    .domain_reset_n(domain_reset_n), .reset_busy(reset_busy), .reset_cause(reset_cause));
  always #5 clk = ~clk;
  // act = clock edges of progress since the last trigger; domain k free once act reaches its slot
  function automatic void m_reset();
    act = 0;
    m_deb = 1'b0;
    rose_pend = 1'b0;
    m_cause = 2'b00;
    pbq = {};
    sh = {};
    repeat (SS) pbq.push_back(1'b0);
  endfunction
  function automatic void m_step(bit pb, bit sw);
    bit seen, btn, old, all_diff;
    if (!reset_n) begin
      m_reset();
      return;
    end
    seen = pbq[SS-1];
    pbq.push_front(pb);
    void'(pbq.pop_back());
    btn = rose_pend;
    old = m_deb;
    sh.push_back(seen);
    if (sh.size() > DB) void'(sh.pop_front());
    all_diff = (sh.size() == DB);
    foreach (sh[i]) if (sh[i] == m_deb) all_diff = 1'b0;
    if (all_diff) begin
      m_deb = !m_deb;
      sh = {};
    end
    rose_pend = m_deb && !old;
    if (btn || sw) begin
      act = 0;
      m_cause = btn ? 2'b01 : 2'b10;
    end else if (act >= POR || !old) act = (act < LAST) ? act + 1 : LAST;
  endfunction
  task automatic check_model();
    logic [N-1:0] ed;
    logic         eb;
    for (int k = 0; k < N; k++) ed[k] = (act >= POR + k * STG);
    eb = (act < LAST);
    vectors++;
    if ({domain_reset_n, reset_busy, reset_cause} !== {ed, eb, m_cause}) begin
      miscompares++;
      $display("FAIL model t=%0t: got dom=%h busy=%b cause=%b, want dom=%h busy=%b cause=%b",
               $time, domain_reset_n, reset_busy, reset_cause, ed, eb, m_cause);
    end
  endtask
  task automatic lit(string name, logic [N-1:0] d, logic b, logic [1:0] c);
    vectors++;
    if ({domain_reset_n, reset_busy, reset_cause} !== {d, b, c}) begin
      miscompares++;
      $display("FAIL %s t=%0t: got dom=%h busy=%b cause=%b, want dom=%h busy=%b cause=%b",
               name, $time, domain_reset_n, reset_busy, reset_cause, d, b, c);
    end
  endtask
  task automatic tick(bit pb, bit sw);
    push_button = pb;
    sw_reset_req = sw;
    @(posedge clk);
    m_step(pb, sw);
    @(negedge clk);
    check_model();
  endtask
  initial begin
    bit lvl;
    int seg;
    m_reset();
    repeat (6) tick(0, 0);
    lit("por_reset", 4'h0, 1'b1, 2'b00);
    reset_n = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick(0, 0);
      if (e == 29) lit("por_e29", 4'h0, 1'b1, 2'b00);
      if (e == 30) lit("por_e30", 4'h1, 1'b1, 2'b00);
      if (e == 40) lit("por_e40", 4'h3, 1'b1, 2'b00);
      if (e == 50) lit("por_e50", 4'h7, 1'b1, 2'b00);
      if (e == 59) lit("por_e59", 4'h7, 1'b1, 2'b00);
      if (e == 60) lit("por_e60", 4'hF, 1'b0, 2'b00);
    end
    tick(0, 1);
    lit("sw_assert", 4'h0, 1'b1, 2'b10);
    for (int i = 1; i <= 65; i++) begin
      tick(0, 0);
      if (i == 29) lit("sw_i29", 4'h0, 1'b1, 2'b10);
      if (i == 30) lit("sw_i30", 4'h1, 1'b1, 2'b10);
      if (i == 60) lit("sw_i60", 4'hF, 1'b0, 2'b10);
    end
    for (int i = 1; i <= 190; i++) begin
      tick(i <= 100, 0);
      if (i == 18) lit("btn_i18", 4'hF, 1'b0, 2'b10);
      if (i == 19) lit("btn_i19", 4'h0, 1'b1, 2'b01);
      if (i == 100) lit("btn_held", 4'h0, 1'b1, 2'b01);
      if (i == 147) lit("btn_i147", 4'h0, 1'b1, 2'b01);
      if (i == 148) lit("btn_i148", 4'h1, 1'b1, 2'b01);
      if (i == 178) lit("btn_i178", 4'hF, 1'b0, 2'b01);
    end
    for (int i = 1; i <= 50; i++) tick(i <= 10, 0);
    lit("glitch", 4'hF, 1'b0, 2'b01);
    tick(0, 1);
    for (int i = 1; i <= 44; i++) tick(0, 0);
    lit("seq_e44", 4'h3, 1'b1, 2'b10);
    tick(0, 1);
    lit("restart", 4'h0, 1'b1, 2'b10);
    for (int i = 1; i <= 60; i++) begin
      tick(0, 0);
      if (i == 30) lit("restart_i30", 4'h1, 1'b1, 2'b10);
      if (i == 60) lit("restart_i60", 4'hF, 1'b0, 2'b10);
    end
    for (int i = 1; i <= 120; i++) begin
      tick(i <= 19, i == 19);
      if (i == 19) lit("both_trig", 4'h0, 1'b1, 2'b01);
    end
    lit("both_run", 4'hF, 1'b0, 2'b01);
    tick(0, 1);
    for (int i = 1; i <= 45; i++) tick(0, 0);
    reset_n = 1'b0;
    #1;
    m_reset();
    lit("async_rst", 4'h0, 1'b1, 2'b00);
    repeat (3) tick(0, 0);
    reset_n = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick(0, 0);
      if (i == 60) lit("after_rst", 4'hF, 1'b0, 2'b00);
    end
    lvl = 1'b0;
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        lvl = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 60);
      end
      seg--;
      tick(lvl, $urandom_range(0, 299) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
